lc3_pipe_ctrl: RTL and testbench

Parametrised pipeline controller for the LC3 core. It drives the fetch/decode/execute/writeback stage enables and resolves branches. It runs a registered memory-access FSM with timeout, and generates forwarding selects over a configurable depth of in-flight producers. It sits between the decode/execute datapath and the instruction and data memory interfaces.

---
 rtl/lc3_pipe_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lc3_pipe_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_ctrl.sv
// LC3 pipeline controller: stage enables, branch resolution, a registered
// data-memory FSM with timeout abort, and operand forwarding selects.
module lc3_pipe_ctrl #(
  parameter int FWD_DEPTH   = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int SW          = $clog2(FWD_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   ir_dec,
  input  logic [15:0]   ir_exec,
  input  logic          exec_valid,
  input  logic [15:0]   imem_dout,
  input  logic          imem_valid,
  input  logic          dmem_complete,
  input  logic [2:0]    nzp,
  input  logic [2:0]    psr,
  output logic          en_update_pc,
  output logic          en_fetch,
  output logic          en_decode,
  output logic          en_execute,
  output logic          en_writeback,
  output logic          br_taken,
  output logic [SW-1:0] fwd_sel_1,
  output logic [SW-1:0] fwd_sel_2,
  output logic          fwd_mem_1,
  output logic          fwd_mem_2,
  output logic [1:0]    mem_state,
  output logic          mem_error
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam int HD = (FWD_DEPTH > 1) ? FWD_DEPTH - 1 : 1;
  localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (MEM_TIMEOUT > 0);
  // The abort is taken in the cycle the count would reach MEM_TIMEOUT.
  localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_READ     = 2'd0,
    S_INDIRECT = 2'd1,
    S_WRITE    = 2'd2,
    S_IDLE     = 2'd3
  } mem_state_t;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  function automatic logic is_load_class(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI) || (op == OP_LEA);
  endfunction

  function automatic logic is_mem_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  function automatic logic is_memop(input logic [3:0] op);
    return is_mem_load(op) || is_store(op);
  endfunction

  logic [3:0]    op_dec;
  logic [3:0]    op_exec;
  mem_state_t    state;
  mem_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic          mem_release;
  logic          ind_store;
  logic          ctrl_pend;
  logic          stall;
  logic          exec_mem;
  logic          timeout;

  logic [HD-1:0] hist_valid;
  logic [HD-1:0] hist_load;
  logic [2:0]    hist_dr [HD];

  logic [FWD_DEPTH-1:0] cand_valid;
  logic [FWD_DEPTH-1:0] cand_load;
  logic [2:0]           cand_dr [FWD_DEPTH];
  logic                 use_1;
  logic                 use_2;
  logic [2:0]           src_1;
  logic [2:0]           src_2;

  logic unused_bits;

  assign op_dec      = ir_dec[15:12];
  assign op_exec     = ir_exec[15:12];
  assign mem_state   = state;
  assign unused_bits = ^{imem_dout[11:0], ir_exec[8:0], ir_dec[4:3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mem_release <= 1'b0;
      mem_error   <= 1'b0;
      ind_store   <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_release <= (state != S_IDLE) && (state_nxt == S_IDLE);
      mem_error   <= mem_error | timeout;
      if (state == S_IDLE) begin
        ind_store <= (op_exec == OP_STI);
      end
      if (state_nxt != state) begin
        cnt <= '0;
      end else if ((state != S_IDLE) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    exec_mem     = exec_valid && is_memop(op_exec);
    timeout      = TMO_EN && (state != S_IDLE) && (cnt == LIMIT) && !dmem_complete;
    stall        = 1'b0;
    en_update_pc = 1'b0;
    en_fetch     = 1'b0;
    en_decode    = 1'b0;
    en_execute   = 1'b0;
    en_writeback = 1'b0;
    case (state)
      S_IDLE: begin
        if (exec_mem && !mem_release) begin
          if ((op_exec == OP_LD) || (op_exec == OP_LDR)) begin
            state_nxt = S_READ;
          end else if ((op_exec == OP_LDI) || (op_exec == OP_STI)) begin
            state_nxt = S_INDIRECT;
          end else begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_INDIRECT: begin
        if (dmem_complete) begin
          state_nxt = ind_store ? S_WRITE : S_READ;
        end else if (timeout) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        if (dmem_complete || timeout) begin
          state_nxt = S_IDLE;
        end
      end
    endcase
    // The release cycle lets the finished MEMOP retire through the normal rules.
    stall = (state != S_IDLE) || (exec_mem && !mem_release);
    if (!rst && !stall) begin
      en_update_pc = !ctrl_pend;
      en_fetch     = !ctrl_pend;
      en_decode    = 1'b1;
      en_execute   = 1'b1;
      en_writeback = !(is_ctrl(op_exec) || is_store(op_exec));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_pend <= 1'b0;
    end else if (imem_valid && is_ctrl(imem_dout[15:12]) && en_fetch) begin
      ctrl_pend <= 1'b1;
    end else if (exec_valid && is_ctrl(op_exec) && !stall) begin
      ctrl_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken <= 1'b0;
    end else if (en_decode) begin
      if (op_dec == OP_JMP) begin
        br_taken <= 1'b1;
      end else if (op_dec == OP_BR) begin
        br_taken <= |(nzp & psr);
      end else begin
        br_taken <= 1'b0;
      end
    end
  end

  // History entry 0 is the producer that most recently left execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid <= '0;
      hist_load  <= '0;
      for (int i = 0; i < HD; i++) begin
        hist_dr[i] <= '0;
      end
    end else if ((FWD_DEPTH > 1) && en_execute && exec_valid) begin
      hist_valid[0] <= is_alu(op_exec) || is_load_class(op_exec);
      hist_load[0]  <= is_mem_load(op_exec);
      hist_dr[0]    <= ir_exec[11:9];
      for (int i = 1; i < HD; i++) begin
        hist_valid[i] <= hist_valid[i-1];
        hist_load[i]  <= hist_load[i-1];
        hist_dr[i]    <= hist_dr[i-1];
      end
    end
  end

  always_comb begin
    use_1 = is_alu(op_dec) || (op_dec == OP_LDR) || (op_dec == OP_STR) || (op_dec == OP_JMP);
    src_1 = ir_dec[8:6];
    use_2 = 1'b0;
    src_2 = ir_dec[2:0];
    if (((op_dec == OP_ADD) || (op_dec == OP_AND)) && !ir_dec[5]) begin
      use_2 = 1'b1;
      src_2 = ir_dec[2:0];
    end else if ((op_dec == OP_ST) || (op_dec == OP_STI) || (op_dec == OP_STR)) begin
      use_2 = 1'b1;
      src_2 = ir_dec[11:9];
    end

    cand_valid[0] = exec_valid && (is_alu(op_exec) || is_load_class(op_exec));
    cand_load[0]  = is_mem_load(op_exec);
    cand_dr[0]    = ir_exec[11:9];
    for (int k = 1; k < FWD_DEPTH; k++) begin
      cand_valid[k] = hist_valid[k-1];
      cand_load[k]  = hist_load[k-1];
      cand_dr[k]    = hist_dr[k-1];
    end

    // Scan oldest to youngest so the youngest match is the one that sticks.
    fwd_sel_1 = '0;
    fwd_sel_2 = '0;
    fwd_mem_1 = 1'b0;
    fwd_mem_2 = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (use_1 && cand_valid[k] && (cand_dr[k] == src_1)) begin
        fwd_sel_1 = SW'(k + 1);
        fwd_mem_1 = cand_load[k];
      end
      if (use_2 && cand_valid[k] && (cand_dr[k] == src_2)) begin
        fwd_sel_2 = SW'(k + 1);
        fwd_mem_2 = cand_load[k];
      end
    end
    if (rst) begin
      fwd_sel_1 = '0;
      fwd_sel_2 = '0;
      fwd_mem_1 = 1'b0;
      fwd_mem_2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl: vectors push expected observations into a
// scoreboard queue which a negedge monitor pops and compares.
module tb_lc3_pipe_ctrl;

  localparam logic [15:0] FILL     = 16'hE000;
  localparam logic [15:0] I_ADD1   = 16'h1283;
  localparam logic [15:0] I_ADD211 = 16'h1441;
  localparam logic [15:0] I_ADD4   = 16'h1883;
  localparam logic [15:0] I_LDR1   = 16'h62C0;
  localparam logic [15:0] I_LD1    = 16'h2200;
  localparam logic [15:0] I_LDI5   = 16'hAA00;
  localparam logic [15:0] I_STI2   = 16'hB400;
  localparam logic [15:0] I_BRZ    = 16'h0400;
  localparam logic [15:0] I_JMP2   = 16'hC080;

  localparam logic [14:0] M_EN  = 15'h7C00;
  localparam logic [14:0] M_BR  = 15'h0200;
  localparam logic [14:0] M_FWD = 15'h01F8;
  localparam logic [14:0] M_ST  = 15'h0006;
  localparam logic [14:0] M_ERR = 15'h0001;
  localparam logic [14:0] M_ALL = 15'h7FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir_dec = FILL;
  logic [15:0] ir_exec = FILL;
  logic        exec_valid = 1'b0;
  logic [15:0] imem_dout = FILL;
  logic        imem_valid = 1'b0;
  logic        dmem_complete = 1'b0;
  logic [2:0]  nzp = 3'b000;
  logic [2:0]  psr = 3'b000;
  logic        en_update_pc, en_fetch, en_decode, en_execute, en_writeback;
  logic        br_taken;
  logic [1:0]  fwd_sel_1, fwd_sel_2;
  logic        fwd_mem_1, fwd_mem_2;
  logic [1:0]  mem_state;
  logic        mem_error;
  logic [14:0] obs;

  lc3_pipe_ctrl #(.FWD_DEPTH(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ir_dec(ir_dec), .ir_exec(ir_exec), .exec_valid(exec_valid),
    .imem_dout(imem_dout), .imem_valid(imem_valid), .dmem_complete(dmem_complete),
    .nzp(nzp), .psr(psr), .en_update_pc(en_update_pc), .en_fetch(en_fetch),
    .en_decode(en_decode), .en_execute(en_execute), .en_writeback(en_writeback),
    .br_taken(br_taken), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
    .fwd_mem_1(fwd_mem_1), .fwd_mem_2(fwd_mem_2), .mem_state(mem_state), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  assign obs = {en_update_pc, en_fetch, en_decode, en_execute, en_writeback, br_taken,
                fwd_sel_1, fwd_sel_2, fwd_mem_1, fwd_mem_2, mem_state, mem_error};

  typedef struct {
    string       name;
    logic        r;
    logic [15:0] ird;
    logic [15:0] ire;
    logic        ev;
    logic [15:0] imd;
    logic        imv;
    logic        dc;
    logic [2:0]  nz;
    logic [2:0]  ps;
    logic [14:0] mask;
    logic [14:0] exp;
  } vec_t;

  typedef struct {
    int          cyc;
    string       name;
    logic [14:0] mask;
    logic [14:0] exp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [14:0] ob(input logic [4:0] en, input logic br, input logic [1:0] s1,
                                     input logic [1:0] s2, input logic m1, input logic m2,
                                     input logic [1:0] st, input logic err);
    return {en, br, s1, s2, m1, m2, st, err};
  endfunction

  function automatic void add(input string name, input logic r, input logic [15:0] ird,
                              input logic [15:0] ire, input logic ev, input logic [15:0] imd,
                              input logic imv, input logic dc, input logic [2:0] nz,
                              input logic [2:0] ps, input logic [14:0] mask, input logic [14:0] exp);
    vec_t v;
    v.name = name; v.r = r; v.ird = ird; v.ire = ire; v.ev = ev; v.imd = imd; v.imv = imv;
    v.dc = dc; v.nz = nz; v.ps = ps; v.mask = mask; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst           = v.r;
    ir_dec        = v.ird;
    ir_exec       = v.ire;
    exec_valid    = v.ev;
    imem_dout     = v.imd;
    imem_valid    = v.imv;
    dmem_complete = v.dc;
    nzp           = v.nz;
    psr           = v.ps;
  endtask

  task automatic checkOutput(input string name, input logic [14:0] mask, input logic [14:0] exp);
    exp_t e;
    e.cyc = cycle; e.name = name; e.mask = mask; e.exp = exp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      mon_e = sb.pop_front();
      checks++;
      if (((obs ^ mon_e.exp) & mon_e.mask) != 15'h0) begin
        errors++;
        $display("[TB] FAIL %s cycle=%0d actual=%h required=%h mask=%h",
                 mon_e.name, cycle, obs & mon_e.mask, mon_e.exp & mon_e.mask, mon_e.mask);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // reset, then release with an ALU op in execute
    add("rst_hold0",  1, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_ALL, ob(5'b00000, 0, 0, 0, 0, 0, 3, 0));
    add("rst_hold1",  1, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_ALL, ob(5'b00000, 0, 0, 0, 0, 0, 3, 0));
    add("rst_exit",   0, FILL, I_ADD1, 1, FILL, 0, 0, 0, 0, M_ALL, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));
    // forwarding from execute, then LDR retirement and forwarding from history
    add("fwd_exec",   0, I_ADD211, I_ADD1, 1, FILL, 0, 0, 0, 0, M_ALL, ob(5'b11111, 0, 1, 1, 0, 0, 3, 0));
    add("ldr_detect", 0, I_ADD211, I_LDR1, 1, FILL, 0, 0, 0, 0, M_ALL, ob(5'b00000, 0, 1, 1, 1, 1, 3, 0));
    add("ldr_read",   0, I_ADD211, I_LDR1, 1, FILL, 0, 1, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    add("ldr_rel",    0, I_ADD211, I_LDR1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));
    add("fwd_hist",   0, I_ADD211, I_ADD4, 1, FILL, 0, 0, 0, 0, M_ALL, ob(5'b11111, 0, 2, 2, 1, 1, 3, 0));
    // LDI with completes at +2 and +4
    add("ldi_detect", 0, FILL, I_LDI5, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 3, 0));
    add("ldi_ind0",   0, FILL, I_LDI5, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 1, 0));
    add("ldi_ind1",   0, FILL, I_LDI5, 1, FILL, 0, 1, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 1, 0));
    add("ldi_read0",  0, FILL, I_LDI5, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    add("ldi_read1",  0, FILL, I_LDI5, 1, FILL, 0, 1, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    add("ldi_rel",    0, FILL, I_LDI5, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));
    add("ldi_after",  0, FILL, FILL, 0, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));
    // STI with completes at +1 and +2; no writeback on release
    add("sti_detect", 0, FILL, I_STI2, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 3, 0));
    add("sti_ind",    0, FILL, I_STI2, 1, FILL, 0, 1, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 1, 0));
    add("sti_write",  0, FILL, I_STI2, 1, FILL, 0, 1, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 2, 0));
    add("sti_rel",    0, FILL, I_STI2, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b11110, 0, 0, 0, 0, 0, 3, 0));
    add("sti_after",  0, FILL, FILL, 0, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));
    // LD whose complete lands exactly on the timeout limit
    add("lim_detect", 0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b00000, 0, 0, 0, 0, 0, 3, 0));
    for (int i = 0; i < 3; i++)
      add("lim_wait", 0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    add("lim_cmpl",   0, FILL, I_LD1, 1, FILL, 0, 1, 0, 0, M_EN | M_ST | M_ERR, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    add("lim_rel",    0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));
    add("lim_noerr",  0, FILL, FILL, 0, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));
    // LD with no complete: abort after 4 cycles in READ
    add("tmo_detect", 0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b00000, 0, 0, 0, 0, 0, 3, 0));
    for (int i = 0; i < 4; i++)
      add("tmo_wait", 0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    add("tmo_rel",    0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b11111, 0, 0, 0, 0, 0, 3, 1));
    add("tmo_sticky", 0, FILL, FILL, 0, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b11111, 0, 0, 0, 0, 0, 3, 1));
    // control hazard and branch resolution
    add("br_fetch",   0, FILL, FILL, 0, I_BRZ, 1, 0, 0, 0, M_EN, ob(5'b11111, 0, 0, 0, 0, 0, 0, 0));
    add("br_decode",  0, I_BRZ, FILL, 0, FILL, 0, 0, 3'b010, 3'b010, M_EN | M_BR, ob(5'b00111, 0, 0, 0, 0, 0, 0, 0));
    add("br_exec",    0, FILL, I_BRZ, 1, FILL, 0, 0, 0, 0, M_EN | M_BR, ob(5'b00110, 1, 0, 0, 0, 0, 0, 0));
    add("jmp_decode", 0, I_JMP2, FILL, 0, FILL, 0, 0, 0, 0, M_EN | M_BR, ob(5'b11111, 0, 0, 0, 0, 0, 0, 0));
    add("br_nt_dec",  0, I_BRZ, FILL, 0, FILL, 0, 0, 3'b010, 3'b100, M_EN | M_BR, ob(5'b11111, 1, 0, 0, 0, 0, 0, 0));
    add("br_nt_res",  0, FILL, FILL, 0, FILL, 0, 0, 0, 0, M_BR, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    // reset in the middle of an access: no release afterwards
    add("mid_detect", 0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b00000, 0, 0, 0, 0, 0, 3, 1));
    add("mid_read",   0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST | M_ERR, ob(5'b00000, 0, 0, 0, 0, 0, 0, 1));
    add("mid_rst",    1, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    add("mid_norel",  0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_ALL, ob(5'b00000, 0, 0, 0, 0, 0, 3, 0));
    add("mid_read2",  0, FILL, I_LD1, 1, FILL, 0, 1, 0, 0, M_EN | M_ST, ob(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    add("mid_rel",    0, FILL, I_LD1, 1, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));
    add("mid_after",  0, FILL, FILL, 0, FILL, 0, 0, 0, 0, M_EN | M_ST, ob(5'b11111, 0, 0, 0, 0, 0, 3, 0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].mask, vecs[i].exp);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
